// File: rtl/cache_bus_arbiter.sv
// N-requester arbiter serialising private-cache requests onto one downstream port.
// Round-robin by default; define ARB_FIXED_PRIORITY_EN for lowest-index-wins priority.
module cache_bus_arbiter #(
  parameter  int NUM_REQ       = 4,
  parameter  int ADDRESS_WIDTH = 32,
  parameter  int DATA_WIDTH    = 32,
  localparam int GRANT_W       = $clog2(NUM_REQ)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_write,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]               resp_valid,
  output logic [DATA_WIDTH-1:0]            resp_rdata,
  output logic                             mem_req_valid,
  output logic                             mem_req_write,
  output logic [ADDRESS_WIDTH-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_wdata,
  input  logic                             mem_req_ready,
  input  logic                             mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]            mem_rdata,
  output logic [GRANT_W-1:0]               grant_id,
  output logic                             busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_nxt;

  logic [NUM_REQ-1:0][ADDRESS_WIDTH-1:0] addr_lane;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    wdata_lane;
  logic [GRANT_W-1:0]                    winner;
  logic                                  any_req;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign addr_lane[g]  = req_addr[g*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign wdata_lane[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  assign any_req = |req_valid;

`ifdef ARB_FIXED_PRIORITY_EN
  always_comb begin
    winner = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req_valid[i]) winner = GRANT_W'(i);
  end
`else
  logic [GRANT_W-1:0] rr_ptr;
  logic               found;

  // Two passes: indices at/above rr_ptr first, then the wrapped lower half.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++)
      if (!found && req_valid[i] && (GRANT_W'(i) >= rr_ptr)) begin
        winner = GRANT_W'(i);
        found  = 1'b1;
      end
    for (int i = 0; i < NUM_REQ; i++)
      if (!found && req_valid[i]) begin
        winner = GRANT_W'(i);
        found  = 1'b1;
      end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      rr_ptr <= '0;
    else if (state == RESP)
      rr_ptr <= (grant_id == GRANT_W'(NUM_REQ - 1)) ? '0 : grant_id + GRANT_W'(1);
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    mem_req_valid = 1'b0;
    busy          = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (any_req) state_nxt = ISSUE;
      end
      ISSUE: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_nxt = WAIT;
      end
      WAIT:    if (mem_resp_valid) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Payload is captured only at grant time, so requesters may change req_* afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_id      <= '0;
      mem_req_write <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      resp_valid    <= '0;
      resp_rdata    <= '0;
    end else begin
      resp_valid <= '0;
      if (state == IDLE && any_req) begin
        grant_id      <= winner;
        mem_req_write <= req_write[winner];
        mem_addr      <= addr_lane[winner];
        mem_wdata     <= wdata_lane[winner];
      end
      if (state == WAIT && mem_resp_valid) begin
        resp_valid <= NUM_REQ'(1) << grant_id;
        resp_rdata <= mem_rdata;
      end
    end
  end

endmodule
